data_ram_wbuf: RTL and testbench
================================

Name: data_ram_wbuf

Overview:
- Responder for the CPU data-memory bus. It receives the MEM stage's ce/we/sel/addr/data and returns read data in the same cycle, so the CPU needs no handshake.
- Backing store is a word-addressed single-port register array.
- A posted write buffer holds stores and drains them into the array only on idle bus cycles, or when forced by a full buffer.
- Reads forward pending buffered bytes over array contents. Stores to the same word coalesce into one buffer entry.

Parameters:
- ADDR_W, 10, log2 of array depth in 32-bit words. The word index is ram_addr_i[ADDR_W+1:2]; upper address bits are ignored, so addresses alias and wrap.
- WBUF_DEPTH, 4, number of write-buffer entries (power of two, 2..8).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ram_ce_i  in  chip_status_t  bus access enable; CHIP_ENABLE means an access this cycle.
- ram_we_i  in  1  1 = store, 0 = load; valid only when ce is enabled.
- ram_sel_i  in  4  byte lanes; bit i covers data[8i+7:8i].
- ram_addr_i  in  ram_addr_t  byte address; bits [1:0] are ignored.
- ram_data_i  in  ram_data_t  store data.
- ram_data_o  out  ram_data_t  load data, combinational, full 32-bit word.
- wbuf_count_o  out  $clog2(WBUF_DEPTH)+1  number of occupied entries (registered).
- wbuf_full_o  out  1  count equals WBUF_DEPTH.

Behaviour:
- Reset (rst=0, asynchronous):
  - All entry valid bits clear; head, tail and count go to 0.
  - wbuf_full_o=0.
  - ram_data_o=0 whenever ce is disabled, in or out of reset.
  - Array contents are not reset.
- Buffer structure:
  - Circular FIFO. Each entry holds: word index (ADDR_W bits), 4-bit byte mask, 32-bit data.
  - Head is the oldest entry, tail is the next free slot.
- Cycle classes, decided on the rising edge; exactly one applies per cycle:
  1. Idle (ce disabled), buffer non-empty: drain the head. Write its masked bytes into array[idx], pop. count-1.
  2. Load (ce enabled, we=0): no drain, because the array port is busy with the read. Buffer unchanged.
  3. Store, hit: the word index matches a valid entry. Merge ram_data_i bytes under ram_sel_i into that entry and OR sel into its mask. No allocation, count unchanged.
     - At most one entry can match, because coalescing guarantees unique indices.
  4. Store, miss, not full: allocate at tail with mask=sel. count+1.
  5. Store, miss, full: in the same cycle, drain the head to the array and allocate the new entry at the freed slot. count unchanged. No store is ever dropped.
- Store with sel=0000:
  - Treated as a no-op; no allocation or merge.
  - An idle-class drain still does not occur on that cycle (the bus is active).
- Load data, combinational:
  - Start from array[idx].
  - For each byte lane, if the matching buffer entry has that mask bit set, take the buffered byte instead.
  - Output the full word regardless of ram_sel_i; the CPU MEM stage extracts and sign-extends.
- Load in the same cycle as the drain in class 5: not possible, since classes are exclusive.
- Load in the cycle after a store: must see the stored bytes via forwarding, 0 cycles of staleness.
- Drain-vs-forward ordering:
  - The array write happens at the clock edge.
  - Forwarding uses registered buffer state, so data is never lost between buffer and array.
- Reset mid-drain:
  - Asynchronous clear discards all pending entries.
  - Un-drained stores are lost. This is accepted; software re-initialises memory after reset.
- Count arithmetic:
  - Width $clog2(WBUF_DEPTH)+1, so no saturation is needed.
  - Head and tail pointers wrap modulo WBUF_DEPTH.

Decomposition:
- Shared package additions:
  - wbuf_entry_t, a packed struct {valid, idx, mask[3:0], data}.
  - constant WBUF_DEPTH_DEFAULT.
  - Reuse the existing ram_addr_t, ram_data_t, chip_status_t and CHIP_ENABLE.
- One natural sub-module: wbuf_fifo.
  - Owns entries, pointers, count, the coalesce-match logic and the forward-merge mux.
  - Exposes head entry, pop, push, merge-hit and forwarded bytes.
- The top contains the array and the cycle-class decode.

Test Plan:
1. Reset, then load 0x0000_0010 with an array preloaded to 0xDEADBEEF.
   -> ram_data_o=0xDEADBEEF, wbuf_count_o=0.
2. Store 0x11223344 sel=1111 to 0x10, then immediately load 0x10.
   -> 0x11223344 (forwarded), count=1.
   - One idle cycle -> count=0, array word 4 = 0x11223344.
3. Store 0xAA sel=0001 to 0x20, then 0xBB00 sel=0010 to 0x20, with array = 0x00000000.
   -> count=1, mask=0011.
   - Load 0x20 -> 0x0000BBAA.
4. Five back-to-back stores to distinct words 0x0,0x4,0x8,0xC,0x10 with no idle cycles (DEPTH=4).
   -> count reaches 4; the fifth cycle drains 0x0 and count stays 4, wbuf_full_o=1.
   - Four idle cycles -> count=0 and all five words correct in the array.
5. Store to 0x1000 with ADDR_W=10.
   -> aliases to word 0; after drain, a load of 0x0 returns the stored value.
6. Three stores queued, then rst asserted low mid-cycle for 1 cycle.
   -> count=0 immediately (asynchronous); loads return the pre-store array values.

Source files
------------

// File: rtl/data_ram_wbuf_pkg.sv
// Shared types for the data-memory responder and its posted write buffer.
package data_ram_wbuf_pkg;

    typedef enum logic {
        CHIP_DISABLE = 1'b0,
        CHIP_ENABLE  = 1'b1
    } chip_status_t;

    typedef logic [31:0] ram_addr_t;
    typedef logic [31:0] ram_data_t;

    localparam int RAM_ADDR_W_DEFAULT = 10;
    localparam int WBUF_DEPTH_DEFAULT = 4;
    // Wide enough for any word index of a 32-bit byte address.
    localparam int WBUF_IDX_W         = 30;

    typedef struct packed {
        logic                  valid;
        logic [WBUF_IDX_W-1:0] idx;
        logic [3:0]            mask;
        ram_data_t             data;
    } wbuf_entry_t;

    function automatic ram_data_t byte_merge(input ram_data_t base,
                                             input ram_data_t upd,
                                             input logic [3:0] m);
        ram_data_t r;
        r = base;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[8*b +: 8] = upd[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/data_ram_wbuf_fifo.sv
// Coalescing circular write buffer: entries, pointers, count, index match
// and forwarding of buffered bytes for the currently addressed word.
module data_ram_wbuf_fifo
    import data_ram_wbuf_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W_DEFAULT,
    parameter int DEPTH  = WBUF_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        lookup_idx_i,
    input  logic                     push_i,
    input  logic                     merge_i,
    input  logic                     pop_i,
    input  logic [3:0]               wr_mask_i,
    input  ram_data_t                wr_data_i,
    output logic                     hit_o,
    output wbuf_entry_t              head_o,
    output logic [3:0]               fwd_mask_o,
    output ram_data_t                fwd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wbuf_entry_t   entries_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] hit_slot;

    // Indices are unique across valid entries, so at most one can match.
    always_comb begin
        hit_o      = 1'b0;
        hit_slot   = '0;
        fwd_mask_o = '0;
        fwd_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries_q[i].valid && entries_q[i].idx[ADDR_W-1:0] == lookup_idx_i) begin
                hit_o      = 1'b1;
                hit_slot   = PW'(i);
                fwd_mask_o = entries_q[i].mask;
                fwd_data_o = entries_q[i].data;
            end
        end
    end

    assign head_o  = entries_q[head_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop_i) begin
                entries_q[head_q].valid <= 1'b0;
                head_q                  <= head_q + PW'(1);
            end
            // When full, tail equals head, so the push reuses the slot just popped.
            if (push_i) begin
                entries_q[tail_q] <= '{valid: 1'b1,
                                       idx:   WBUF_IDX_W'(lookup_idx_i),
                                       mask:  wr_mask_i,
                                       data:  wr_data_i};
                tail_q            <= tail_q + PW'(1);
            end
            if (merge_i) begin
                entries_q[hit_slot].mask <= entries_q[hit_slot].mask | wr_mask_i;
                entries_q[hit_slot].data <= byte_merge(entries_q[hit_slot].data,
                                                       wr_data_i, wr_mask_i);
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

endmodule

// File: rtl/data_ram_wbuf.sv
// Zero-wait data-memory responder: word array plus posted write buffer that
// drains on idle bus cycles or when a miss finds the buffer full.
module data_ram_wbuf
    import data_ram_wbuf_pkg::*;
#(
    parameter int ADDR_W     = RAM_ADDR_W_DEFAULT,
    parameter int WBUF_DEPTH = WBUF_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  chip_status_t                ram_ce_i,
    input  logic                        ram_we_i,
    input  logic [3:0]                  ram_sel_i,
    input  ram_addr_t                   ram_addr_i,
    input  ram_data_t                   ram_data_i,
    output ram_data_t                   ram_data_o,
    output logic [$clog2(WBUF_DEPTH):0] wbuf_count_o,
    output logic                        wbuf_full_o
);

    ram_data_t         mem_q [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic              ce_en, store_act, hit, push, merge, pop;
    wbuf_entry_t       head;
    logic [3:0]        fwd_mask;
    ram_data_t         fwd_data;
    logic              unused_bits;

    assign idx       = ram_addr_i[ADDR_W+1:2];
    assign ce_en     = (ram_ce_i == CHIP_ENABLE);
    // A store with no lanes selected still occupies the bus, so it also blocks draining.
    assign store_act = ce_en && ram_we_i && (ram_sel_i != 4'b0000);
    assign merge     = store_act && hit;
    assign push      = store_act && !hit;
    assign pop       = (!ce_en && (wbuf_count_o != '0)) || (push && wbuf_full_o);

    data_ram_wbuf_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (WBUF_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .lookup_idx_i (idx),
        .push_i       (push),
        .merge_i      (merge),
        .pop_i        (pop),
        .wr_mask_i    (ram_sel_i),
        .wr_data_i    (ram_data_i),
        .hit_o        (hit),
        .head_o       (head),
        .fwd_mask_o   (fwd_mask),
        .fwd_data_o   (fwd_data),
        .count_o      (wbuf_count_o),
        .full_o       (wbuf_full_o)
    );

    always_ff @(posedge clk) begin
        if (pop) begin
            mem_q[head.idx[ADDR_W-1:0]] <= byte_merge(mem_q[head.idx[ADDR_W-1:0]],
                                                      head.data, head.mask);
        end
    end

    assign ram_data_o = ce_en ? byte_merge(mem_q[idx], fwd_data, fwd_mask) : '0;

    assign unused_bits = ^{ram_addr_i[31:ADDR_W+2], ram_addr_i[1:0],
                           head.valid, head.idx[WBUF_IDX_W-1:ADDR_W]};

endmodule

// File: tb/tb_data_ram_wbuf.sv
// Bench for data_ram_wbuf: vector table with a load-data scoreboard plus a reset sequence.
module tb_data_ram_wbuf;
    import data_ram_wbuf_pkg::*;

    localparam int OP_I = 0;
    localparam int OP_L = 1;
    localparam int OP_S = 2;

    logic         clk;
    logic         rst;
    chip_status_t ram_ce_i;
    logic         ram_we_i;
    logic [3:0]   ram_sel_i;
    ram_addr_t    ram_addr_i;
    ram_data_t    ram_data_i;
    ram_data_t    ram_data_o;
    logic [2:0]   wbuf_count_o;
    logic         wbuf_full_o;

    data_ram_wbuf #(.ADDR_W(10), .WBUF_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .ram_ce_i     (ram_ce_i),
        .ram_we_i     (ram_we_i),
        .ram_sel_i    (ram_sel_i),
        .ram_addr_i   (ram_addr_i),
        .ram_data_i   (ram_data_i),
        .ram_data_o   (ram_data_o),
        .wbuf_count_o (wbuf_count_o),
        .wbuf_full_o  (wbuf_full_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        int          cnt;
        logic        full;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    logic [31:0] model [1024];
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input int op, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] sel, input int cnt, input logic full);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.sel = sel; v.cnt = cnt; v.full = full;
        vecs.push_back(v);
    endfunction

    task automatic drive(input int op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] sel);
        logic [31:0] exp;
        logic [31:0] m;
        ram_ce_i   = (op == OP_I) ? CHIP_DISABLE : CHIP_ENABLE;
        ram_we_i   = (op == OP_S);
        ram_sel_i  = (op == OP_I) ? 4'b0000 : sel;
        ram_addr_i = (op == OP_I) ? 32'h0 : addr;
        ram_data_i = (op == OP_S) ? data : 32'h0;
        if (op != OP_S) exp_q.push_back((op == OP_L) ? model[addr[11:2]] : 32'h0);
        @(negedge clk);
        if (op != OP_S) begin
            exp = exp_q.pop_front();
            check((op == OP_L) ? "load_data" : "idle_data", ram_data_o, exp);
        end else begin
            m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
            model[addr[11:2]] = (model[addr[11:2]] & ~m) | (data & m);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) model[i] = 32'h0;
        // Preload, forward, drain
        add(OP_S, 32'h10, 32'hDEADBEEF, 4'hF, 1, 0);
        add(OP_I, 32'h0,  32'h0,        4'h0, 0, 0);
        add(OP_L, 32'h10, 32'h0,        4'hF, 0, 0);
        add(OP_S, 32'h10, 32'h11223344, 4'hF, 1, 0);
        add(OP_L, 32'h10, 32'h0,        4'hF, 1, 0);
        add(OP_I, 32'h0,  32'h0,        4'h0, 0, 0);
        add(OP_L, 32'h10, 32'h0,        4'hF, 0, 0);
        // Coalescing of byte stores on a zeroed word
        add(OP_S, 32'h20, 32'h00000000, 4'hF, 1, 0);
        add(OP_I, 32'h0,  32'h0,        4'h0, 0, 0);
        add(OP_S, 32'h20, 32'h000000AA, 4'h1, 1, 0);
        add(OP_S, 32'h20, 32'h0000BB00, 4'h2, 1, 0);
        add(OP_L, 32'h20, 32'h0,        4'hF, 1, 0);
        add(OP_I, 32'h0,  32'h0,        4'h0, 0, 0);
        add(OP_L, 32'h20, 32'h0,        4'hF, 0, 0);
        // Partial forward over array bytes
        add(OP_S, 32'h10, 32'h00550000, 4'h4, 1, 0);
        add(OP_L, 32'h10, 32'h0,        4'h1, 1, 0);
        add(OP_I, 32'h0,  32'h0,        4'h0, 0, 0);
        add(OP_L, 32'h10, 32'h0,        4'hF, 0, 0);
        // sel=0 stores: no allocation and no drain
        add(OP_S, 32'h10, 32'hFFFFFFFF, 4'h0, 0, 0);
        add(OP_L, 32'h10, 32'h0,        4'hF, 0, 0);
        add(OP_S, 32'h24, 32'h12345678, 4'hF, 1, 0);
        add(OP_S, 32'h10, 32'hFFFFFFFF, 4'h0, 1, 0);
        add(OP_I, 32'h0,  32'h0,        4'h0, 0, 0);
        add(OP_L, 32'h24, 32'h0,        4'hF, 0, 0);
        // Fill to full, miss-on-full drains head, hit-on-full merges
        add(OP_S, 32'h00, 32'hA0000000, 4'hF, 1, 0);
        add(OP_S, 32'h04, 32'hA0000001, 4'hF, 2, 0);
        add(OP_S, 32'h08, 32'hA0000002, 4'hF, 3, 0);
        add(OP_S, 32'h0C, 32'hA0000003, 4'hF, 4, 1);
        add(OP_S, 32'h10, 32'hA0000004, 4'hF, 4, 1);
        add(OP_L, 32'h00, 32'h0,        4'hF, 4, 1);
        add(OP_L, 32'h10, 32'h0,        4'hF, 4, 1);
        add(OP_S, 32'h08, 32'h000000EE, 4'h1, 4, 1);
        add(OP_L, 32'h08, 32'h0,        4'hF, 4, 1);
        add(OP_I, 32'h0,  32'h0,        4'h0, 3, 0);
        add(OP_I, 32'h0,  32'h0,        4'h0, 2, 0);
        add(OP_I, 32'h0,  32'h0,        4'h0, 1, 0);
        add(OP_I, 32'h0,  32'h0,        4'h0, 0, 0);
        add(OP_I, 32'h0,  32'h0,        4'h0, 0, 0);
        for (int a = 0; a < 5; a++) add(OP_L, 32'(a * 4), 32'h0, 4'hF, 0, 0);
        // Address aliasing above the array size
        add(OP_S, 32'h1000, 32'h5A5A5A5A, 4'hF, 1, 0);
        add(OP_I, 32'h0,    32'h0,        4'h0, 0, 0);
        add(OP_L, 32'h0,    32'h0,        4'hF, 0, 0);
        add(OP_L, 32'h1000, 32'h0,        4'hF, 0, 0);

        rst        = 1'b0;
        ram_ce_i   = CHIP_DISABLE;
        ram_we_i   = 1'b0;
        ram_sel_i  = 4'h0;
        ram_addr_i = 32'h0;
        ram_data_i = 32'h0;
        repeat (2) @(posedge clk);
        #3;
        check("reset_count", 32'(wbuf_count_o), 32'h0);
        check("reset_full", 32'(wbuf_full_o), 32'h0);
        check("reset_data", ram_data_o, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].sel);
            check($sformatf("count_v%0d", i), 32'(wbuf_count_o), 32'(vecs[i].cnt));
            check($sformatf("full_v%0d", i), 32'(wbuf_full_o), 32'(vecs[i].full));
        end

        // Reset with stores pending: buffered data is discarded
        drive(OP_S, 32'h40, 32'h11111111, 4'hF);
        drive(OP_S, 32'h44, 32'h22222222, 4'hF);
        drive(OP_S, 32'h48, 32'h33333333, 4'hF);
        repeat (3) drive(OP_I, 32'h0, 32'h0, 4'h0);
        drive(OP_S, 32'h40, 32'hAAAAAAAA, 4'hF);
        drive(OP_S, 32'h44, 32'hBBBBBBBB, 4'hF);
        drive(OP_S, 32'h48, 32'hCCCCCCCC, 4'h3);
        check("pre_reset_count", 32'(wbuf_count_o), 32'h3);
        ram_ce_i  = CHIP_DISABLE;
        ram_we_i  = 1'b0;
        ram_sel_i = 4'h0;
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_count", 32'(wbuf_count_o), 32'h0);
        check("async_reset_full", 32'(wbuf_full_o), 32'h0);
        check("async_reset_data", ram_data_o, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        model[16] = 32'h11111111;
        model[17] = 32'h22222222;
        model[18] = 32'h33333333;
        drive(OP_L, 32'h40, 32'h0, 4'hF);
        drive(OP_L, 32'h44, 32'h0, 4'hF);
        drive(OP_L, 32'h48, 32'h0, 4'hF);
        check("post_reset_count", 32'(wbuf_count_o), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
